uart_tx: RTL

UART_TX -- requirements
Module: uart_tx

---
 rtl/uart_pkg.sv | 5 +
 rtl/uart_tx_if.sv | 8 +
 rtl/uart_baud_cnt.sv | 14 +
 rtl/uart_tx.sv | 77 +++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding and idle line level shared by uart_tx and any future uart_rx
package uart_pkg;
   typedef enum logic [2:0] {IDLE = 3'd0, START = 3'd1, DATA = 3'd2, PARITY = 3'd3, STOP = 3'd4} uart_state_t;
   localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/uart_tx_if.sv
// uart_tx_if: valid/ready payload handshake into uart_tx
interface uart_tx_if #(parameter int DATA_BITS = 8);
   logic [DATA_BITS-1:0] tx_data;
   logic tx_valid;
   logic tx_ready;
   modport master(output tx_data, tx_valid, input tx_ready);
   modport slave(input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/uart_baud_cnt.sv
// uart_baud_cnt: bit-period counter, tick on count CLKS_PER_BIT-1 then wrap to 0
module uart_baud_cnt #(parameter int CLKS_PER_BIT = 16) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   output logic tick
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   logic [CW-1:0] cnt;
   assign tick = cnt == CW'(CLKS_PER_BIT - 1);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) cnt <= '0;
      else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx.sv
// uart_tx: start/data(LSB first)/stop serializer; define UART_TX_PARITY_EN to add an even parity bit
module uart_tx import uart_pkg::*; #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   uart_tx_if.slave   bus,
   output logic       txd,
   output logic       busy
);
   localparam int IW = $clog2(DATA_BITS);
   uart_state_t state, state_nx;
   logic [DATA_BITS-1:0] shreg, shreg_nx;
   logic [IW-1:0] bit_idx, bit_idx_nx;
   logic txd_nx, tick, last;
   uart_baud_cnt #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (.clk(clk), .rst_n(rst_n), .clear(state == IDLE), .tick(tick));
   assign busy = state != IDLE;
   assign bus.tx_ready = state == IDLE;
   assign last = bit_idx == IW'(DATA_BITS - 1);
   // shreg rotates rather than shifts, so after the last data bit it holds the payload again for parity
   always_comb begin
      state_nx = state;
      shreg_nx = shreg;
      bit_idx_nx = bit_idx;
      txd_nx = txd;
      case (state)
         IDLE: if (bus.tx_valid) begin
            state_nx = START;
            shreg_nx = bus.tx_data;
            bit_idx_nx = '0;
            txd_nx = 1'b0;
         end
         START: if (tick) begin
            state_nx = DATA;
            txd_nx = shreg[0];
         end
         DATA: if (tick) begin
            shreg_nx = {shreg[0], shreg[DATA_BITS-1:1]};
            bit_idx_nx = last ? bit_idx : bit_idx + 1'b1;
`ifdef UART_TX_PARITY_EN
            state_nx = last ? PARITY : DATA;
            txd_nx = last ? ^shreg : shreg[1];
`else
            state_nx = last ? STOP : DATA;
            txd_nx = last ? 1'b1 : shreg[1];
`endif
         end
`ifdef UART_TX_PARITY_EN
         PARITY: if (tick) begin
            state_nx = STOP;
            txd_nx = 1'b1;
         end
`endif
         STOP: if (tick) begin
            state_nx = IDLE;
            txd_nx = IDLE_LEVEL;
         end
         default: begin
            state_nx = IDLE;
            txd_nx = IDLE_LEVEL;
         end
      endcase
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state <= IDLE;
         shreg <= '0;
         bit_idx <= '0;
         txd <= IDLE_LEVEL;
      end else begin
         state <= state_nx;
         shreg <= shreg_nx;
         bit_idx <= bit_idx_nx;
         txd <= txd_nx;
      end
endmodule
